// File: rtl/ddr_native_mem_responder_if.sv
// Native DDR application interface: command, write-data and read-return
// channels plus the calibration and protocol-error status lines.
interface ddr_native_mem_responder_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic                    app_rdy;
  logic [DATA_WIDTH-1:0]   app_wdf_data;
  logic [DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic [DATA_WIDTH-1:0]   app_rd_data;
  logic                    app_rd_data_valid;
  logic                    app_rd_data_end;
  logic                    init_calib_complete;
  logic                    err_wdf_end;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, err_wdf_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, err_wdf_end
  );
endinterface

// File: rtl/ddr_native_mem_responder.sv
// Behavioural DDR native-interface responder: in-order command FIFO, write
// data FIFO, byte-masked backing memory and a fixed-latency read return pipe.
module ddr_native_mem_responder #(
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 256,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int READ_LATENCY   = 8,
  parameter int CALIB_CYCLES   = 64,
  parameter int CMD_DEPTH      = 4,
  parameter int WDF_DEPTH      = 4,
  parameter int RD_MAX         = 16
) (
  input logic                       ui_clock,
  input logic                       ui_rst,
  ddr_native_mem_responder_if.slave app
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int CMD_PW     = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CMD_CW     = $clog2(CMD_DEPTH + 1);
  localparam int WDF_PW     = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
  localparam int WDF_CW     = $clog2(WDF_DEPTH + 1);
  localparam int RD_CW      = $clog2(RD_MAX + 1);
  localparam int CAL_CW     = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;

  typedef enum logic [0:0] {
    ST_CALIB = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [CAL_CW-1:0]        calib_cnt_r;

  logic [2:0]               cmd_op_r  [CMD_DEPTH];
  logic [MEM_DEPTH_LOG2-1:0] cmd_idx_r [CMD_DEPTH];
  logic [CMD_PW-1:0]        cmd_wp_r;
  logic [CMD_PW-1:0]        cmd_rp_r;
  logic [CMD_CW-1:0]        cmd_cnt_r;

  logic [DATA_WIDTH-1:0]    wdf_data_r [WDF_DEPTH];
  logic [MASK_WIDTH-1:0]    wdf_mask_r [WDF_DEPTH];
  logic [WDF_PW-1:0]        wdf_wp_r;
  logic [WDF_PW-1:0]        wdf_rp_r;
  logic [WDF_CW-1:0]        wdf_cnt_r;

  logic [RD_CW-1:0]         rd_cnt_r;
  logic                     err_r;

  logic [DATA_WIDTH-1:0]    mem_r [MEM_DEPTH];
  logic [READ_LATENCY-1:0]  vld_pipe_r;
  logic [DATA_WIDTH-1:0]    dat_pipe_r [READ_LATENCY];

  logic                     live_s;
  logic                     calib_done_s;
  logic                     app_rdy_s;
  logic                     app_wdf_rdy_s;
  logic                     cmd_push_s;
  logic                     wdf_push_s;
  logic                     rd_accept_s;
  logic                     rd_ret_s;
  logic [2:0]               head_op_s;
  logic [MEM_DEPTH_LOG2-1:0] head_idx_s;
  logic [DATA_WIDTH-1:0]    head_data_s;
  logic [MASK_WIDTH-1:0]    head_mask_s;
  logic                     cmd_pop_s;
  logic                     wdf_pop_s;
  logic                     mem_we_s;
  logic                     rd_exec_s;
  logic                     unused_addr_s;

  function automatic logic [CMD_PW-1:0] cmd_ptr_next(input logic [CMD_PW-1:0] p);
    return (p == CMD_PW'(CMD_DEPTH - 1)) ? {CMD_PW{1'b0}} : p + CMD_PW'(1);
  endfunction

  function automatic logic [WDF_PW-1:0] wdf_ptr_next(input logic [WDF_PW-1:0] p);
    return (p == WDF_PW'(WDF_DEPTH - 1)) ? {WDF_PW{1'b0}} : p + WDF_PW'(1);
  endfunction

  // Only the word-index slice of the address matters; the rest wraps away.
  assign unused_addr_s = ^app.app_addr;

  assign live_s        = ~ui_rst;
  assign calib_done_s  = (state_r == ST_READY);
  assign app_rdy_s     = live_s & calib_done_s & (cmd_cnt_r < CMD_CW'(CMD_DEPTH))
                         & (rd_cnt_r < RD_CW'(RD_MAX));
  assign app_wdf_rdy_s = live_s & calib_done_s & (wdf_cnt_r < WDF_CW'(WDF_DEPTH));
  assign cmd_push_s    = app.app_en & app_rdy_s;
  assign wdf_push_s    = app.app_wdf_wren & app_wdf_rdy_s;
  assign rd_accept_s   = cmd_push_s & (app.app_cmd == 3'b001);
  assign rd_ret_s      = vld_pipe_r[READ_LATENCY-1];

  assign head_op_s     = cmd_op_r[cmd_rp_r];
  assign head_idx_s    = cmd_idx_r[cmd_rp_r];
  assign head_data_s   = wdf_data_r[wdf_rp_r];
  assign head_mask_s   = wdf_mask_r[wdf_rp_r];

  // Outputs are forced low for the whole time reset is held.
  assign app.app_rdy             = app_rdy_s;
  assign app.app_wdf_rdy         = app_wdf_rdy_s;
  assign app.app_rd_data         = live_s ? dat_pipe_r[READ_LATENCY-1] : {DATA_WIDTH{1'b0}};
  assign app.app_rd_data_valid   = live_s & rd_ret_s;
  assign app.app_rd_data_end     = live_s & rd_ret_s;
  assign app.init_calib_complete = live_s & calib_done_s;
  assign app.err_wdf_end         = live_s & err_r;

  // Calibration state register and post-reset cycle counter.
  always_ff @(posedge ui_clock) begin
    if (ui_rst) begin
      state_r     <= ST_CALIB;
      calib_cnt_r <= {CAL_CW{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == ST_CALIB) begin
        calib_cnt_r <= calib_cnt_r + CAL_CW'(1);
      end
    end
  end

  // Calibration completes after CALIB_CYCLES clean cycles, then stays ready.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CALIB: begin
        if (calib_cnt_r == CAL_CW'(CALIB_CYCLES - 1)) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_CALIB;
        end
      end
      ST_READY: state_s = ST_READY;
      default:  state_s = ST_CALIB;
    endcase
  end

  // Head execution: writes wait for data, reads and no-ops always retire.
  always_comb begin
    cmd_pop_s = 1'b0;
    wdf_pop_s = 1'b0;
    mem_we_s  = 1'b0;
    rd_exec_s = 1'b0;
    if (live_s && (cmd_cnt_r != {CMD_CW{1'b0}})) begin
      case (head_op_s)
        3'b000: begin
          if (wdf_cnt_r != {WDF_CW{1'b0}}) begin
            cmd_pop_s = 1'b1;
            wdf_pop_s = 1'b1;
            mem_we_s  = 1'b1;
          end else begin
            cmd_pop_s = 1'b0;
          end
        end
        3'b001: begin
          cmd_pop_s = 1'b1;
          rd_exec_s = 1'b1;
        end
        default: cmd_pop_s = 1'b1;
      endcase
    end else begin
      cmd_pop_s = 1'b0;
    end
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge ui_clock) begin
    if (ui_rst) begin
      cmd_wp_r  <= {CMD_PW{1'b0}};
      cmd_rp_r  <= {CMD_PW{1'b0}};
      cmd_cnt_r <= {CMD_CW{1'b0}};
    end else begin
      if (cmd_push_s) cmd_wp_r <= cmd_ptr_next(cmd_wp_r);
      if (cmd_pop_s)  cmd_rp_r <= cmd_ptr_next(cmd_rp_r);
      cmd_cnt_r <= cmd_cnt_r + CMD_CW'(cmd_push_s) - CMD_CW'(cmd_pop_s);
    end
  end

  // Command FIFO storage.
  always_ff @(posedge ui_clock) begin
    if (cmd_push_s) begin
      cmd_op_r[cmd_wp_r]  <= app.app_cmd;
      cmd_idx_r[cmd_wp_r] <= app.app_addr[3 +: MEM_DEPTH_LOG2];
    end
  end

  // Write-data FIFO pointers and occupancy.
  always_ff @(posedge ui_clock) begin
    if (ui_rst) begin
      wdf_wp_r  <= {WDF_PW{1'b0}};
      wdf_rp_r  <= {WDF_PW{1'b0}};
      wdf_cnt_r <= {WDF_CW{1'b0}};
    end else begin
      if (wdf_push_s) wdf_wp_r <= wdf_ptr_next(wdf_wp_r);
      if (wdf_pop_s)  wdf_rp_r <= wdf_ptr_next(wdf_rp_r);
      wdf_cnt_r <= wdf_cnt_r + WDF_CW'(wdf_push_s) - WDF_CW'(wdf_pop_s);
    end
  end

  // Write-data FIFO storage.
  always_ff @(posedge ui_clock) begin
    if (wdf_push_s) begin
      wdf_data_r[wdf_wp_r] <= app.app_wdf_data;
      wdf_mask_r[wdf_wp_r] <= app.app_wdf_mask;
    end
  end

  // Reads outstanding (queued plus in the return pipe) and sticky end error.
  always_ff @(posedge ui_clock) begin
    if (ui_rst) begin
      rd_cnt_r <= {RD_CW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      rd_cnt_r <= rd_cnt_r + RD_CW'(rd_accept_s) - RD_CW'(rd_ret_s);
      if (wdf_push_s && !app.app_wdf_end) err_r <= 1'b1;
    end
  end

  // Backing memory: byte-masked commit at the write execute cycle, never reset.
  always_ff @(posedge ui_clock) begin
    if (mem_we_s) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!head_mask_s[b]) mem_r[head_idx_s][b*8 +: 8] <= head_data_s[b*8 +: 8];
      end
    end
  end

  // Read return pipe; each data stage only loads behind a valid, so the last
  // stage keeps the most recent returned word between pulses.
  always_ff @(posedge ui_clock) begin
    if (ui_rst) begin
      vld_pipe_r <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) dat_pipe_r[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      vld_pipe_r[0] <= rd_exec_s;
      if (rd_exec_s) dat_pipe_r[0] <= mem_r[head_idx_s];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i-1];
        if (vld_pipe_r[i-1]) dat_pipe_r[i] <= dat_pipe_r[i-1];
      end
    end
  end
endmodule

// File: tb/tb_ddr_native_mem_responder.sv
// Directed self-checking bench for ddr_native_mem_responder.
module tb_ddr_native_mem_responder;
  localparam int AW = 27;
  localparam int DW = 256;
  localparam int MW = DW / 8;
  localparam int RL = 24;

  logic ui_clock = 1'b0;
  logic ui_rst   = 1'b1;
  int   errors   = 0;
  int   checks   = 0;

  ddr_native_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app ();

  ddr_native_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(10), .READ_LATENCY(RL),
    .CALIB_CYCLES(64), .CMD_DEPTH(4), .WDF_DEPTH(4), .RD_MAX(16)
  ) dut (
    .ui_clock(ui_clock),
    .ui_rst  (ui_rst),
    .app     (app)
  );

  always #5 ui_clock = ~ui_clock;

  task automatic tick();
    @(posedge ui_clock);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [MW-1:0] mask, input logic wend);
    int guard;
    app.app_addr = addr; app.app_cmd = 3'b000; app.app_en = 1'b1;
    app.app_wdf_data = data; app.app_wdf_mask = mask; app.app_wdf_end = wend;
    app.app_wdf_wren = 1'b1;
    guard = 0;
    while (!(app.app_rdy && app.app_wdf_rdy) && guard < 200) begin tick(); guard++; end
    tick();
    app.app_en = 1'b0; app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b1;
  endtask

  task automatic read_word(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output int lat, output logic end_seen, output logic valid_after);
    int guard;
    data = '0; lat = 0; end_seen = 1'b0; valid_after = 1'b0;
    app.app_addr = addr; app.app_cmd = 3'b001; app.app_en = 1'b1;
    guard = 0;
    while (!app.app_rdy && guard < 200) begin tick(); guard++; end
    tick();
    app.app_en = 1'b0;
    for (int n = 1; n <= 3 * RL; n++) begin
      tick();
      if (app.app_rd_data_valid) begin
        lat = n; data = app.app_rd_data; end_seen = app.app_rd_data_end;
        break;
      end
    end
    tick();
    valid_after = app.app_rd_data_valid;
  endtask

  task automatic test_reset();
    ui_rst = 1'b1;
    repeat (3) tick();
    checks++; if (app.app_rdy !== 1'b0) begin errors++; $display("FAIL reset_app_rdy: got %b want 0", app.app_rdy); end
    checks++; if (app.app_wdf_rdy !== 1'b0) begin errors++; $display("FAIL reset_wdf_rdy: got %b want 0", app.app_wdf_rdy); end
    checks++; if (app.app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", app.app_rd_data_valid); end
    checks++; if (app.app_rd_data_end !== 1'b0) begin errors++; $display("FAIL reset_end: got %b want 0", app.app_rd_data_end); end
    checks++; if (app.init_calib_complete !== 1'b0) begin errors++; $display("FAIL reset_calib: got %b want 0", app.init_calib_complete); end
    checks++; if (app.err_wdf_end !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", app.err_wdf_end); end
    checks++; if (app.app_rd_data !== {DW{1'b0}}) begin errors++; $display("FAIL reset_rd_data: got %h want 0", app.app_rd_data); end
  endtask

  task automatic test_calibration();
    int early;
    early = 0;
    ui_rst = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      tick();
      if (app.init_calib_complete || app.app_rdy || app.app_wdf_rdy) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL calib_early: got %0d high cycles want 0", early); end
    tick();
    checks++; if (app.init_calib_complete !== 1'b1) begin errors++; $display("FAIL calib_done: got %b want 1", app.init_calib_complete); end
    checks++; if (app.app_rdy !== 1'b1) begin errors++; $display("FAIL calib_app_rdy: got %b want 1", app.app_rdy); end
    checks++; if (app.app_wdf_rdy !== 1'b1) begin errors++; $display("FAIL calib_wdf_rdy: got %b want 1", app.app_wdf_rdy); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d; int lat; logic e; logic va;
    write_word(27'h40, {32{8'hA5}}, {MW{1'b0}}, 1'b1);
    read_word(27'h40, d, lat, e, va);
    checks++; if (d !== {32{8'hA5}}) begin errors++; $display("FAIL wr_rd_data: got %h want %h", d, {32{8'hA5}}); end
    checks++; if (lat !== RL) begin errors++; $display("FAIL wr_rd_latency: got %0d want %0d", lat, RL); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_rd_end: got %b want 1", e); end
    checks++; if (va !== 1'b0) begin errors++; $display("FAIL wr_rd_single_pulse: got %b want 0", va); end
    checks++; if (app.app_rd_data !== {32{8'hA5}}) begin errors++; $display("FAIL rd_data_hold: got %h want %h", app.app_rd_data, {32{8'hA5}}); end
  endtask

  task automatic test_noop();
    logic [DW-1:0] d; int lat; logic e; logic va;
    app.app_addr = 27'h40; app.app_cmd = 3'b111; app.app_en = 1'b1;
    tick();
    app.app_en = 1'b0;
    read_word(27'h40, d, lat, e, va);
    checks++; if (d !== {32{8'hA5}}) begin errors++; $display("FAIL noop_data: got %h want %h", d, {32{8'hA5}}); end
    checks++; if (lat !== RL) begin errors++; $display("FAIL noop_latency: got %0d want %0d", lat, RL); end
  endtask

  task automatic test_mask_early_data();
    logic [DW-1:0] d; int lat; logic e; logic va; int guard;
    write_word(27'h80, {32{8'hFF}}, {MW{1'b0}}, 1'b1);
    app.app_wdf_data = {32{8'h11}}; app.app_wdf_mask = 32'h0000_0001;
    app.app_wdf_end = 1'b1; app.app_wdf_wren = 1'b1;
    guard = 0;
    while (!app.app_wdf_rdy && guard < 200) begin tick(); guard++; end
    tick();
    app.app_wdf_wren = 1'b0;
    repeat (3) tick();
    app.app_addr = 27'h80; app.app_cmd = 3'b000; app.app_en = 1'b1;
    guard = 0;
    while (!app.app_rdy && guard < 200) begin tick(); guard++; end
    tick();
    app.app_en = 1'b0;
    // Aliased address: low 3 bits and bit 13 lie outside the word index.
    read_word(27'h0002087, d, lat, e, va);
    checks++; if (d !== {{31{8'h11}}, 8'hFF}) begin errors++; $display("FAIL mask_data: got %h want %h", d, {{31{8'h11}}, 8'hFF}); end
    checks++; if (app.err_wdf_end !== 1'b0) begin errors++; $display("FAIL mask_err_clear: got %b want 0", app.err_wdf_end); end
  endtask

  task automatic test_wdf_end();
    logic [DW-1:0] d; int lat; logic e; logic va;
    write_word(27'h200, {32{8'h3C}}, {MW{1'b0}}, 1'b0);
    checks++; if (app.err_wdf_end !== 1'b1) begin errors++; $display("FAIL wdf_end_err: got %b want 1", app.err_wdf_end); end
    read_word(27'h200, d, lat, e, va);
    checks++; if (d !== {32{8'h3C}}) begin errors++; $display("FAIL wdf_end_stored: got %h want %h", d, {32{8'h3C}}); end
    checks++; if (app.err_wdf_end !== 1'b1) begin errors++; $display("FAIL wdf_end_sticky: got %b want 1", app.err_wdf_end); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d; int lat; logic e; logic va; int bad; int guard; logic [7:0] b;
    bad = 0;
    app.app_cmd = 3'b000;
    for (int i = 0; i < 4; i++) begin
      app.app_addr = 27'h100 + 27'(8 * i); app.app_en = 1'b1;
      if (!app.app_rdy) bad++;
      tick();
    end
    app.app_addr = 27'h120;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_accept4: got %0d stalls want 0", bad); end
    checks++; if (app.app_rdy !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", app.app_rdy); end
    tick();
    checks++; if (app.app_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b want 0", app.app_rdy); end
    app.app_wdf_data = {32{8'h50}}; app.app_wdf_mask = {MW{1'b0}}; app.app_wdf_end = 1'b1;
    app.app_wdf_wren = 1'b1;
    tick();
    app.app_wdf_wren = 1'b0;
    checks++; if (app.app_rdy !== 1'b0) begin errors++; $display("FAIL bp_beat_cycle: got %b want 0", app.app_rdy); end
    tick();
    checks++; if (app.app_rdy !== 1'b1) begin errors++; $display("FAIL bp_reassert: got %b want 1", app.app_rdy); end
    tick();
    app.app_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b = 8'h50 + 8'(i);
      app.app_wdf_data = {32{b}}; app.app_wdf_wren = 1'b1;
      guard = 0;
      while (!app.app_wdf_rdy && guard < 200) begin tick(); guard++; end
      tick();
    end
    app.app_wdf_wren = 1'b0;
    read_word(27'h100, d, lat, e, va);
    checks++; if (d !== {32{8'h50}}) begin errors++; $display("FAIL bp_first: got %h want %h", d, {32{8'h50}}); end
    read_word(27'h108, d, lat, e, va);
    checks++; if (d !== {32{8'h51}}) begin errors++; $display("FAIL bp_second: got %h want %h", d, {32{8'h51}}); end
    read_word(27'h120, d, lat, e, va);
    checks++; if (d !== {32{8'h54}}) begin errors++; $display("FAIL bp_fifth: got %h want %h", d, {32{8'h54}}); end
  endtask

  task automatic test_inflight_and_reset();
    logic [DW-1:0] d; logic [DW-1:0] exp; int lat; logic e; logic va;
    int bad; int got; int cal;
    bad = 0;
    app.app_cmd = 3'b001;
    for (int i = 0; i < 16; i++) begin
      app.app_addr = (i % 2 == 0) ? 27'h40 : 27'h200; app.app_en = 1'b1;
      if (!app.app_rdy) bad++;
      tick();
    end
    app.app_en = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL inflight_accept16: got %0d stalls want 0", bad); end
    checks++; if (app.app_rdy !== 1'b0) begin errors++; $display("FAIL inflight_limit: got %b want 0", app.app_rdy); end
    got = 0; bad = 0;
    for (int n = 0; n < 3 * RL && got < 5; n++) begin
      tick();
      if (app.app_rd_data_valid) begin
        exp = (got % 2 == 0) ? {32{8'hA5}} : {32{8'h3C}};
        if (app.app_rd_data !== exp) bad++;
        got++;
      end
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL inflight_returns: got %0d want 5", got); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL inflight_order: got %0d wrong words want 0", bad); end
    ui_rst = 1'b1;
    #1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (app.app_rd_data_valid) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_drop: got %0d valid cycles want 0", bad); end
    checks++;
    if ({app.app_rdy, app.app_wdf_rdy, app.init_calib_complete, app.err_wdf_end} !== 4'b0000 || app.app_rd_data !== {DW{1'b0}}) begin
      errors++; $display("FAIL reset_outputs: got %b data %h want 0000 and 0",
        {app.app_rdy, app.app_wdf_rdy, app.init_calib_complete, app.err_wdf_end}, app.app_rd_data);
    end
    ui_rst = 1'b0;
    cal = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (app.init_calib_complete) begin cal = k; break; end
    end
    checks++; if (cal !== 64) begin errors++; $display("FAIL recal_cycles: got %0d want 64", cal); end
    checks++; if (app.err_wdf_end !== 1'b0) begin errors++; $display("FAIL recal_err: got %b want 0", app.err_wdf_end); end
    checks++; if (app.app_rd_data_valid !== 1'b0) begin errors++; $display("FAIL recal_no_valid: got %b want 0", app.app_rd_data_valid); end
    read_word(27'h40, d, lat, e, va);
    checks++; if (d !== {32{8'hA5}}) begin errors++; $display("FAIL retain_40: got %h want %h", d, {32{8'hA5}}); end
    read_word(27'h200, d, lat, e, va);
    checks++; if (d !== {32{8'h3C}}) begin errors++; $display("FAIL retain_200: got %h want %h", d, {32{8'h3C}}); end
  endtask

  initial begin
    app.app_addr = '0; app.app_cmd = 3'b000; app.app_en = 1'b0;
    app.app_wdf_data = '0; app.app_wdf_mask = '0; app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b1;
    test_reset();
    test_calibration();
    test_write_read();
    test_noop();
    test_mask_early_data();
    test_wdf_end();
    test_backpressure();
    test_inflight_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
